// File: rtl/pc_stack.sv
// pc_stack: program-counter sequencer with an internal return-address stack.
// All state advances on the falling edge of CLK. One action is chosen per edge
// in the order Stall > INTjmp (when no interrupt frame is live) > Ret > call >
// jmp > br > PCpp > hold; lower-priority strobes in the same cycle are dropped.
// Each stack entry carries a tag bit marking interrupt frames, so a return
// through that frame releases the interrupt lockout.

module pc_stack #(
    parameter int             AW      = 16,
    parameter int             OW      = 8,
    parameter int             DEPTH   = 8,
    parameter logic [AW-1:0]  RST_VEC = {AW{1'b0}}
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       Stall,
    input  logic                       PCpp,
    input  logic                       jmp,
    input  logic                       br,
    input  logic                       call,
    input  logic                       Ret,
    input  logic                       INTjmp,
    input  logic                       ErrClr,
    input  logic [AW-1:0]              Imm,
    input  logic [AW-1:0]              Aint,
    input  logic [OW-1:0]              Off,
    output logic [AW-1:0]              ADDRout,
    output logic [AW-1:0]              TOS,
    output logic [$clog2(DEPTH+1)-1:0] SP,
    output logic                       Full,
    output logic                       Empty,
    output logic                       IntBusy,
    output logic                       Ovf,
    output logic                       Unf
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    // Architectural state
    logic [AW-1:0]  addr_r;
    logic [SPW-1:0] sp_r;
    logic           intbusy_r;
    logic           ovf_r;
    logic           unf_r;
    logic [AW:0]    stack_r [DEPTH];

    // Next-state and decode signals
    logic [AW-1:0]  addr_nxt_s;
    logic [SPW-1:0] sp_nxt_s;
    logic           intbusy_nxt_s;
    logic           ovf_set_s;
    logic           unf_set_s;
    logic           ovf_nxt_s;
    logic           unf_nxt_s;
    logic           wr_en_s;
    logic [AW:0]    wr_ent_s;
    logic [IW-1:0]  wr_idx_s;
    logic [IW-1:0]  tos_idx_s;
    logic [AW:0]    tos_ent_s;
    logic           full_s;
    logic           empty_s;
    logic           int_take_s;
    logic [AW-1:0]  off_ext_s;
    logic [AW-1:0]  addr_inc_s;

    assign full_s     = (sp_r == SP_FULL);
    assign empty_s    = (sp_r == {SPW{1'b0}});
    assign int_take_s = INTjmp & ~intbusy_r;
    assign off_ext_s  = {{(AW-OW){Off[OW-1]}}, Off};
    assign addr_inc_s = addr_r + AW'(1);

    // The write slot is the first free entry; the top entry sits one below it.
    assign wr_idx_s  = IW'(sp_r);
    assign tos_idx_s = IW'(sp_r - SPW'(1));
    assign tos_ent_s = stack_r[tos_idx_s];

    // Choose this cycle's single action and compute the resulting state.
    always_comb begin
        addr_nxt_s    = addr_r;
        sp_nxt_s      = sp_r;
        intbusy_nxt_s = intbusy_r;
        ovf_set_s     = 1'b0;
        unf_set_s     = 1'b0;
        wr_en_s       = 1'b0;
        wr_ent_s      = {(AW+1){1'b0}};

        if (Stall) begin
            addr_nxt_s = addr_r;
        end else if (int_take_s) begin
            // Interrupted address is saved unincremented so it re-executes.
            wr_ent_s      = {1'b1, addr_r};
            intbusy_nxt_s = 1'b1;
            addr_nxt_s    = Aint;
            if (full_s) begin
                ovf_set_s = 1'b1;
            end else begin
                wr_en_s  = 1'b1;
                sp_nxt_s = sp_r + SPW'(1);
            end
        end else if (Ret) begin
            if (empty_s) begin
                unf_set_s = 1'b1;
            end else begin
                addr_nxt_s = tos_ent_s[AW-1:0];
                sp_nxt_s   = sp_r - SPW'(1);
                if (tos_ent_s[AW]) begin
                    intbusy_nxt_s = 1'b0;
                end else begin
                    intbusy_nxt_s = intbusy_r;
                end
            end
        end else if (call) begin
            wr_ent_s   = {1'b0, addr_inc_s};
            addr_nxt_s = Imm;
            if (full_s) begin
                ovf_set_s = 1'b1;
            end else begin
                wr_en_s  = 1'b1;
                sp_nxt_s = sp_r + SPW'(1);
            end
        end else if (jmp) begin
            addr_nxt_s = Imm;
        end else if (br) begin
            addr_nxt_s = addr_r + off_ext_s;
        end else if (PCpp) begin
            addr_nxt_s = addr_inc_s;
        end else begin
            addr_nxt_s = addr_r;
        end
    end

    // A new error in the same cycle beats a clear; clears work even while stalled.
    assign ovf_nxt_s = ovf_set_s | (ovf_r & ~ErrClr);
    assign unf_nxt_s = unf_set_s | (unf_r & ~ErrClr);

    // Update PC, stack pointer, interrupt lockout and sticky error flags.
    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            addr_r    <= RST_VEC;
            sp_r      <= {SPW{1'b0}};
            intbusy_r <= 1'b0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            addr_r    <= addr_nxt_s;
            sp_r      <= sp_nxt_s;
            intbusy_r <= intbusy_nxt_s;
            ovf_r     <= ovf_nxt_s;
            unf_r     <= unf_nxt_s;
        end
    end

    // Stack storage; contents are meaningless above SP so no reset is needed.
    always_ff @(negedge CLK) begin
        if (wr_en_s) begin
            stack_r[wr_idx_s] <= wr_ent_s;
        end
    end

    assign ADDRout = addr_r;
    assign SP      = sp_r;
    assign TOS     = empty_s ? {AW{1'b0}} : tos_ent_s[AW-1:0];
    assign Full    = full_s;
    assign Empty   = empty_s;
    assign IntBusy = intbusy_r;
    assign Ovf     = ovf_r;
    assign Unf     = unf_r;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed vector table, hand-written corner sequences,
// then randomized strobes checked against a queue-based reference model.

module tb_pc_stack;

    localparam int          AW    = 16;
    localparam int          OW    = 8;
    localparam int          DEPTH = 8;
    localparam logic [15:0] RV    = 16'h0100;

    localparam logic [7:0] O_ST = 8'h80;
    localparam logic [7:0] O_IJ = 8'h40;
    localparam logic [7:0] O_RT = 8'h20;
    localparam logic [7:0] O_CL = 8'h10;
    localparam logic [7:0] O_JP = 8'h08;
    localparam logic [7:0] O_BR = 8'h04;
    localparam logic [7:0] O_PP = 8'h02;
    localparam logic [7:0] O_EC = 8'h01;

    logic        CLK = 1'b1;
    logic        RSTn = 1'b0;
    logic        Stall = 1'b0, PCpp = 1'b0, jmp = 1'b0, br = 1'b0;
    logic        call = 1'b0, Ret = 1'b0, INTjmp = 1'b0, ErrClr = 1'b0;
    logic [15:0] Imm = 16'h0, Aint = 16'h0;
    logic [7:0]  Off = 8'h0;
    logic [15:0] ADDRout, TOS;
    logic [3:0]  SP;
    logic        Full, Empty, IntBusy, Ovf, Unf;

    pc_stack #(.AW(AW), .OW(OW), .DEPTH(DEPTH), .RST_VEC(RV)) dut (
        .CLK(CLK), .RSTn(RSTn), .Stall(Stall), .PCpp(PCpp), .jmp(jmp), .br(br),
        .call(call), .Ret(Ret), .INTjmp(INTjmp), .ErrClr(ErrClr),
        .Imm(Imm), .Aint(Aint), .Off(Off),
        .ADDRout(ADDRout), .TOS(TOS), .SP(SP), .Full(Full), .Empty(Empty),
        .IntBusy(IntBusy), .Ovf(Ovf), .Unf(Unf)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of saved return frames plus PC and flags.
    typedef struct { bit tag; logic [15:0] a; } ent_t;
    ent_t        mq[$];
    logic [15:0] m_addr;
    bit          m_ib, m_ovf, m_unf;

    typedef struct {
        logic [7:0]  ops;
        logic [15:0] imm, aint;
        logic [7:0]  off;
        logic [15:0] e_addr;
        int          e_sp;
        logic [15:0] e_tos;
        logic        e_ib, e_ovf, e_unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] ops, logic [15:0] imm, logic [15:0] aint,
                                logic [7:0] off, logic [15:0] ea, int esp,
                                logic [15:0] etos, logic eib, logic eovf, logic eunf);
        vec_t v;
        v.ops = ops; v.imm = imm; v.aint = aint; v.off = off;
        v.e_addr = ea; v.e_sp = esp; v.e_tos = etos;
        v.e_ib = eib; v.e_ovf = eovf; v.e_unf = eunf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_addr = RV;
        m_ib = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // Apply the current strobes to the model, following the priority rules.
    task automatic model_step();
        bit   os, us;
        ent_t e;
        os = 1'b0; us = 1'b0;
        if (Stall) begin
            os = 1'b0;
        end else if (INTjmp && !m_ib) begin
            if (mq.size() == DEPTH) os = 1'b1;
            else mq.push_back('{1'b1, m_addr});
            m_ib = 1'b1;
            m_addr = Aint;
        end else if (Ret) begin
            if (mq.size() == 0) us = 1'b1;
            else begin
                e = mq.pop_back();
                m_addr = e.a;
                if (e.tag) m_ib = 1'b0;
            end
        end else if (call) begin
            if (mq.size() == DEPTH) os = 1'b1;
            else mq.push_back('{1'b0, 16'(int'(m_addr) + 1)});
            m_addr = Imm;
        end else if (jmp) begin
            m_addr = Imm;
        end else if (br) begin
            m_addr = 16'(int'(m_addr) + int'($signed(Off)));
        end else if (PCpp) begin
            m_addr = 16'(int'(m_addr) + 1);
        end
        m_ovf = os | (m_ovf & !ErrClr);
        m_unf = us | (m_unf & !ErrClr);
    endtask

    task automatic check_model(input string tag);
        logic [15:0] etos;
        etos = (mq.size() == 0) ? 16'h0 : mq[mq.size()-1].a;
        chk({tag, ".addr"},  32'(ADDRout), 32'(m_addr));
        chk({tag, ".sp"},    32'(SP),      32'(mq.size()));
        chk({tag, ".tos"},   32'(TOS),     32'(etos));
        chk({tag, ".full"},  32'(Full),    32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(Empty),   32'(mq.size() == 0));
        chk({tag, ".ib"},    32'(IntBusy), 32'(m_ib));
        chk({tag, ".ovf"},   32'(Ovf),     32'(m_ovf));
        chk({tag, ".unf"},   32'(Unf),     32'(m_unf));
    endtask

    // Drive strobes from the rising edge, sample #1 after the falling edge.
    task automatic drive(input logic [7:0] ops, input logic [15:0] imm,
                         input logic [15:0] aint, input logic [7:0] off);
        @(posedge CLK);
        Stall = ops[7]; INTjmp = ops[6]; Ret = ops[5]; call = ops[4];
        jmp = ops[3]; br = ops[2]; PCpp = ops[1]; ErrClr = ops[0];
        Imm = imm; Aint = aint; Off = off;
        @(negedge CLK);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        @(posedge CLK);
        RSTn = 1'b0;
        Stall = 1'b0; INTjmp = 1'b0; Ret = 1'b0; call = 1'b0;
        jmp = 1'b0; br = 1'b0; PCpp = 1'b0; ErrClr = 1'b0;
        #12;
        model_reset();
        @(posedge CLK);
        RSTn = 1'b1;
    endtask

    initial begin
        // ops, imm, aint, off, exp addr, sp, tos, ib, ovf, unf
        tbl.push_back(mk(O_PP,      16'h0, 16'h0, 8'h0, 16'h0101, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_PP,      16'h0, 16'h0, 8'h0, 16'h0102, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_PP,      16'h0, 16'h0, 8'h0, 16'h0103, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_JP, 16'h0010, 16'h0, 8'h0, 16'h0010, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_CL, 16'h2000, 16'h0, 8'h0, 16'h2000, 1, 16'h0011, 0, 0, 0));
        tbl.push_back(mk(O_CL, 16'h3000, 16'h0, 8'h0, 16'h3000, 2, 16'h2001, 0, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h2001, 1, 16'h0011, 0, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h0011, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_JP, 16'h0040, 16'h0, 8'h0, 16'h0040, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_IJ, 16'h0, 16'h0F00, 8'h0, 16'h0F00, 1, 16'h0040, 1, 0, 0));
        tbl.push_back(mk(O_IJ|O_PP, 16'h0, 16'h0F00, 8'h0, 16'h0F01, 1, 16'h0040, 1, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h0040, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_JP, 16'hFFFF, 16'h0, 8'h0, 16'hFFFF, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_PP,      16'h0, 16'h0, 8'h0, 16'h0000, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_JP, 16'h0005, 16'h0, 8'h0, 16'h0005, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_BR,      16'h0, 16'h0, 8'hFE, 16'h0003, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_JP, 16'hFFF0, 16'h0, 8'h0, 16'hFFF0, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_BR,      16'h0, 16'h0, 8'h7F, 16'h006F, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_CL|O_JP|O_PP, 16'h1234, 16'h0, 8'h0, 16'h1234, 1, 16'h0070, 0, 0, 0));
        tbl.push_back(mk(O_ST|O_IJ, 16'h0, 16'h0F00, 8'h0, 16'h1234, 1, 16'h0070, 0, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h0070, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_JP, 16'hFFFF, 16'h0, 8'h0, 16'hFFFF, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_CL, 16'h0500, 16'h0, 8'h0, 16'h0500, 1, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h0000, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h0000, 0, 16'h0, 0, 0, 1));
        tbl.push_back(mk(O_RT|O_EC, 16'h0, 16'h0, 8'h0, 16'h0000, 0, 16'h0, 0, 0, 1));
        tbl.push_back(mk(O_EC,      16'h0, 16'h0, 8'h0, 16'h0000, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h0000, 0, 16'h0, 0, 0, 1));
        tbl.push_back(mk(O_ST|O_EC|O_PP, 16'h0, 16'h0, 8'h0, 16'h0000, 0, 16'h0, 0, 0, 0));
        tbl.push_back(mk(O_IJ, 16'h0, 16'h0F00, 8'h0, 16'h0F00, 1, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(O_CL, 16'h0A00, 16'h0, 8'h0, 16'h0A00, 2, 16'h0F01, 1, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h0F01, 1, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(O_RT,      16'h0, 16'h0, 8'h0, 16'h0000, 0, 16'h0, 0, 0, 0));

        // Reset state
        do_reset();
        #1;
        chk("rst.addr",  32'(ADDRout), 32'h0100);
        chk("rst.sp",    32'(SP),      32'h0);
        chk("rst.empty", 32'(Empty),   32'h1);
        chk("rst.full",  32'(Full),    32'h0);
        chk("rst.tos",   32'(TOS),     32'h0);
        chk("rst.flags", 32'({IntBusy, Ovf, Unf}), 32'h0);

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ops, tbl[i].imm, tbl[i].aint, tbl[i].off);
            chk($sformatf("vec%0d.addr", i), 32'(ADDRout), 32'(tbl[i].e_addr));
            chk($sformatf("vec%0d.sp", i),   32'(SP),      32'(tbl[i].e_sp));
            chk($sformatf("vec%0d.tos", i),  32'(TOS),     32'(tbl[i].e_tos));
            chk($sformatf("vec%0d.ib", i),   32'(IntBusy), 32'(tbl[i].e_ib));
            chk($sformatf("vec%0d.ovf", i),  32'(Ovf),     32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d.unf", i),  32'(Unf),     32'(tbl[i].e_unf));
            chk($sformatf("vec%0d.empty", i), 32'(Empty),  32'(tbl[i].e_sp == 0));
        end

        // Overflow then underflow, then clear
        do_reset();
        drive(O_JP, 16'h0200, 16'h0, 8'h0);
        for (int i = 0; i < 9; i++) begin
            drive(O_CL, 16'(32'h1000 + i), 16'h0, 8'h0);
            check_model($sformatf("ovf.call%0d", i));
        end
        chk("ovf.addr", 32'(ADDRout), 32'h1008);
        chk("ovf.sp",   32'(SP),      32'h8);
        chk("ovf.flag", 32'(Ovf),     32'h1);
        chk("ovf.full", 32'(Full),    32'h1);
        for (int i = 0; i < 8; i++) begin
            drive(O_RT, 16'h0, 16'h0, 8'h0);
            check_model($sformatf("unf.ret%0d", i));
        end
        chk("unf.last_pop", 32'(ADDRout), 32'h0201);
        drive(O_RT, 16'h0, 16'h0, 8'h0);
        chk("unf.hold", 32'(ADDRout), 32'h0201);
        chk("unf.sp",   32'(SP),      32'h0);
        chk("unf.flag", 32'(Unf),     32'h1);
        drive(O_EC, 16'h0, 16'h0, 8'h0);
        chk("errclr", 32'({Ovf, Unf}), 32'h0);

        // Interrupt while full: still vectors and locks out
        for (int i = 0; i < 8; i++) drive(O_CL, 16'(32'h2000 + i), 16'h0, 8'h0);
        drive(O_IJ, 16'h0, 16'h0F00, 8'h0);
        chk("intfull.addr", 32'(ADDRout), 32'h0F00);
        chk("intfull.ib",   32'(IntBusy), 32'h1);
        chk("intfull.ovf",  32'(Ovf),     32'h1);
        chk("intfull.sp",   32'(SP),      32'h8);

        // Asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 3; i++) drive(O_CL, 16'(32'h3000 + 16 * i), 16'h0, 8'h0);
        chk("arst.pre_sp", 32'(SP), 32'h3);
        @(posedge CLK);
        Stall = 1'b0; INTjmp = 1'b0; Ret = 1'b0; call = 1'b0;
        jmp = 1'b0; br = 1'b0; ErrClr = 1'b0; PCpp = 1'b1;
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        chk("arst.sp",    32'(SP),      32'h0);
        chk("arst.addr",  32'(ADDRout), 32'h0100);
        chk("arst.empty", 32'(Empty),   32'h1);
        chk("arst.tos",   32'(TOS),     32'h0);
        @(negedge CLK);
        #1;
        chk("arst.held", 32'(ADDRout), 32'h0100);
        @(posedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        #1;
        model_step();
        chk("arst.first", 32'(ADDRout), 32'h0101);
        check_model("arst.model");

        // Randomized strobes against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ops;
            if (i % 500 == 0) do_reset();
            ops[7] = ($urandom_range(0, 99) < 5);
            ops[6] = ($urandom_range(0, 99) < 10);
            ops[5] = ($urandom_range(0, 99) < 30);
            ops[4] = ($urandom_range(0, 99) < 30);
            ops[3] = ($urandom_range(0, 99) < 8);
            ops[2] = ($urandom_range(0, 99) < 15);
            ops[1] = ($urandom_range(0, 99) < 40);
            ops[0] = ($urandom_range(0, 99) < 6);
            drive(ops, 16'($urandom), 16'($urandom), 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
